// File: rtl/board_debug_ctrl.sv
// Board debug controller: debounced buttons, step/run CPU clock enable,
// probe channel selection for the display, and PC breakpoint halt.
module board_debug_ctrl #(
   parameter int unsigned CH_NUM    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DB_CYCLES = 1_000_000,
   parameter int unsigned RUN_DIV   = 50_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       btn_step,
   input  logic                       btn_next,
   input  logic                       btn_prev,
   input  logic                       btn_run,
   input  logic [CH_NUM*DATA_W-1:0]   probe_data,
   input  logic [31:0]                pc,
   input  logic                       bp_en,
   input  logic [31:0]                bp_addr,
   output logic                       cpu_clk_en,
   output logic [$clog2(CH_NUM)-1:0]  sel,
   output logic [DATA_W-1:0]          disp_data,
   output logic                       run_mode,
   output logic                       bp_hit,
   output logic [15:0]                step_cnt
);

   localparam int unsigned SEL_W = $clog2(CH_NUM);
   localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
   localparam int unsigned DIV_W = $clog2(RUN_DIV);
   localparam int unsigned NBTN  = 4;

   typedef enum logic {ST_STEP, ST_RUN} state_t;

   logic [NBTN-1:0]  btn_raw, sync1, sync2, stable, stable_d, press;
   logic [CNT_W-1:0] db_cnt [NBTN];
   logic             press_step, press_next, press_prev, press_run;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic             bp_hit_nxt, pulse_nxt, bp_match;
   logic [DATA_W-1:0] sel_word;

   assign btn_raw    = {btn_run, btn_prev, btn_next, btn_step};
   assign press_step = press[0];
   assign press_next = press[1];
   assign press_prev = press[2];
   assign press_run  = press[3];

   // Stable level only moves after DB_CYCLES consecutive mismatching samples.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_d <= '0;
         press    <= '0;
         for (int unsigned i = 0; i < NBTN; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         stable_d <= stable;
         press    <= stable & ~stable_d;
         for (int unsigned i = 0; i < NBTN; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sel <= '0;
      end else if (press_next && !press_prev) begin
         sel <= (sel == SEL_W'(CH_NUM - 1)) ? '0 : sel + SEL_W'(1);
      end else if (press_prev && !press_next) begin
         sel <= (sel == '0) ? SEL_W'(CH_NUM - 1) : sel - SEL_W'(1);
      end
   end

   always_comb begin
      sel_word = '0;
      for (int unsigned k = 0; k < CH_NUM; k++) begin
         if (sel == SEL_W'(k)) sel_word = probe_data[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) disp_data <= '0;
      else      disp_data <= sel_word;
   end

   assign bp_match = bp_en && (pc == bp_addr);

   // Breakpoint outranks both a run-toggle press and a due divider pulse.
   always_comb begin
      state_nxt  = state;
      div_nxt    = div;
      bp_hit_nxt = bp_hit;
      pulse_nxt  = 1'b0;
      case (state)
         ST_STEP: begin
            if (press_step) pulse_nxt = 1'b1;
            if (press_run) begin
               state_nxt  = ST_RUN;
               div_nxt    = '0;
               bp_hit_nxt = 1'b0;
            end
         end
         ST_RUN: begin
            if (bp_match) begin
               state_nxt  = ST_STEP;
               bp_hit_nxt = 1'b1;
            end else if (press_run) begin
               state_nxt = ST_STEP;
            end else if (div == DIV_W'(RUN_DIV - 1)) begin
               div_nxt   = '0;
               pulse_nxt = 1'b1;
            end else begin
               div_nxt = div + DIV_W'(1);
            end
         end
         default: state_nxt = ST_STEP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_STEP;
         div        <= '0;
         bp_hit     <= 1'b0;
         cpu_clk_en <= 1'b0;
         step_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         div        <= div_nxt;
         bp_hit     <= bp_hit_nxt;
         cpu_clk_en <= pulse_nxt;
         step_cnt   <= step_cnt + 16'(pulse_nxt);
      end
   end

   assign run_mode = (state == ST_RUN);

endmodule

// File: tb/tb_board_debug_ctrl.sv
// Self-checking bench for board_debug_ctrl: scoreboard of expected
// cpu_clk_en pulse cycles plus direct checks of select/display/mode state.
module tb_board_debug_ctrl;

   localparam int unsigned CH = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned DB = 4;
   localparam int unsigned RD = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [3:0]        btns = '0;
   logic [CH*DW-1:0]  probe_data;
   logic [31:0]       pc, bp_addr;
   logic              bp_en;
   logic              cpu_clk_en, run_mode, bp_hit;
   logic [1:0]        sel;
   logic [DW-1:0]     disp_data;
   logic [15:0]       step_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulse_n = 0;
   int pc_base = 0;
   int exp_q[$];

   board_debug_ctrl #(.CH_NUM(CH), .DATA_W(DW), .DB_CYCLES(DB), .RUN_DIV(RD)) dut (
      .clk(clk), .rst(rst),
      .btn_step(btns[0]), .btn_next(btns[1]), .btn_prev(btns[2]), .btn_run(btns[3]),
      .probe_data(probe_data), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
      .cpu_clk_en(cpu_clk_en), .sel(sel), .disp_data(disp_data),
      .run_mode(run_mode), .bp_hit(bp_hit), .step_cnt(step_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // CPU model: PC advances by 4 on each issued clock enable.
   always @(posedge clk) if (cpu_clk_en === 1'b1) pulse_n <= pulse_n + 1;
   assign pc = 32'((pulse_n - pc_base) * 4);

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cpu_clk_en === 1'b1) begin
         if (exp_q.size() == 0) chk("pulse_unexpected", exp_q.size(), 1);
         else                   chk("pulse_cycle", cyc, exp_q.pop_front());
      end
   end

   function automatic logic [31:0] ch_init(input int k);
      return (k == 3) ? 32'hDEADBEEF : 32'hA0A0_0000 + 32'(k);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic press(input int idx, input int hold, input int post,
                        input bit want_pulse, output int t0);
      t0 = cyc;
      if (want_pulse) exp_q.push_back(t0 + 8);
      btns[idx] = 1'b1;
      tick(hold);
      btns[idx] = 1'b0;
      if (post > 0) tick(post);
   endtask

   task automatic chk_reset_outs();
      chk("rst_cpu_clk_en", cpu_clk_en, 0);
      chk("rst_sel", sel, 0);
      chk("rst_disp_data", disp_data, 0);
      chk("rst_run_mode", run_mode, 0);
      chk("rst_bp_hit", bp_hit, 0);
      chk("rst_step_cnt", step_cnt, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int t, t2, n;
      bp_en   = 1'b0;
      bp_addr = '0;
      for (int k = 0; k < CH; k++) probe_data[k*DW +: DW] = ch_init(k);

      rst = 1'b0;
      tick(3);
      chk_reset_outs();
      rst = 1'b1;
      tick(2);

      // Debounce: short glitch ignored, long hold gives exactly one pulse
      btns[0] = 1'b1;
      tick(3);
      btns[0] = 1'b0;
      tick(20);
      chk("glitch_step_cnt", step_cnt, 0);
      press(0, 20, 12, 1'b1, t);
      chk("held_step_cnt", step_cnt, 1);

      // Channel select wrap
      for (int k = 1; k <= 4; k++) begin
         press(1, 6, 10, 1'b0, t);
         chk("sel_next", sel, k % 4);
      end
      chk("disp_ch0", disp_data, ch_init(0));

      press(2, 6, 0, 1'b0, t);
      n = 0;
      while (sel != 2'd3 && n < 20) begin
         tick(1);
         n++;
      end
      chk("prev_wrap_sel", sel, 3);
      chk("prev_sel_cycle", cyc, t + 8);
      chk("disp_before_update", disp_data, ch_init(0));
      tick(1);
      chk("disp_ch3", disp_data, 32'hDEADBEEF);
      tick(10);

      probe_data[3*DW +: DW] = 32'h1234_5678;
      chk("disp_probe_hold", disp_data, 32'hDEADBEEF);
      tick(1);
      chk("disp_probe_live", disp_data, 32'h1234_5678);

      btns[2:1] = 2'b11;
      tick(6);
      btns[2:1] = 2'b00;
      tick(12);
      chk("sel_both_pressed", sel, 3);

      // Reset mid-debounce discards the partial count
      btns[1] = 1'b1;
      tick(4);
      rst = 1'b0;
      btns[1] = 1'b0;
      tick(1);
      chk_reset_outs();
      rst = 1'b1;
      tick(15);
      chk("sel_after_reset_debounce", sel, 0);

      // Run mode: 5 pulses, step press ignored, run press stops
      press(3, 6, 0, 1'b0, t);
      for (int k = 0; k < 5; k++) exp_q.push_back(t + 16 + 8*k);
      wait_until(t + 8);
      chk("run_mode_on", run_mode, 1);
      wait_until(t + 20);
      press(0, 6, 0, 1'b0, t2);
      wait_until(t + 45);
      press(3, 6, 0, 1'b0, t2);
      wait_until(t + 53);
      chk("run_mode_off", run_mode, 0);
      tick(30);
      chk("run_step_cnt", step_cnt, 5);

      // Breakpoint at PC 0x10
      bp_addr = 32'h10;
      bp_en   = 1'b1;
      pc_base = pulse_n;
      press(3, 6, 0, 1'b0, t);
      for (int k = 0; k < 4; k++) exp_q.push_back(t + 16 + 8*k);
      wait_until(t + 8);
      chk("bp_run_mode_on", run_mode, 1);
      n = 0;
      while (run_mode != 1'b0 && n < 100) begin
         tick(1);
         n++;
      end
      chk("bp_run_mode_off", run_mode, 0);
      chk("bp_halt_cycle", cyc, t + 42);
      chk("bp_hit_set", bp_hit, 1);
      chk("bp_pc", pc, 32'h10);
      tick(20);
      chk("bp_step_cnt", step_cnt, 9);
      bp_en = 1'b0;
      press(3, 6, 2, 1'b0, t);
      chk("bp_rerun_mode", run_mode, 1);
      chk("bp_hit_cleared", bp_hit, 0);

      // Reset while running with sel=2, step_cnt=7
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(2);
      press(1, 6, 10, 1'b0, t);
      press(1, 6, 10, 1'b0, t);
      for (int k = 0; k < 7; k++) press(0, 6, 10, 1'b1, t);
      chk("pre_rst_step_cnt", step_cnt, 7);
      chk("pre_rst_sel", sel, 2);
      press(3, 6, 2, 1'b0, t);
      chk("pre_rst_run_mode", run_mode, 1);
      rst = 1'b0;
      tick(1);
      chk_reset_outs();
      rst = 1'b1;
      tick(20);
      chk("post_rst_run_mode", run_mode, 0);
      chk("post_rst_step_cnt", step_cnt, 0);

      chk("pulse_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_debug_ctrl.md
# board_debug_ctrl

Parametrised board-level debug controller between the FPGA board's push-buttons/7-segment display and the CPU under test. It debounces the board buttons and generates a single-step or free-running CPU clock enable. It selects one of `CH_NUM` debug probe words for the `Display` block, and halts free-running execution on a PC breakpoint. It replaces the ad-hoc `swb`-edge clocking and `case`-based display muxing in board top levels with one synchronous, single-clock block.

## Interface
- `CH_NUM`, 8: number of probe channels (≥2).
- `DATA_W`, 32: width of each probe word and of `disp_data`.
- `DB_CYCLES`, 1_000_000: consecutive stable samples required to accept a button level change.
- `RUN_DIV`, 50_000_000: run-mode period in `clk` cycles between `cpu_clk_en` pulses (≥2).
- `clk` in 1: board clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `btn_step` in 1: raw button; one CPU step per press (step mode only).
- `btn_next` in 1: raw button; select next probe channel.
- `btn_prev` in 1: raw button; select previous probe channel.
- `btn_run` in 1: raw button; toggle step/run mode.
- `probe_data` in `CH_NUM*DATA_W`: channel k at bits `[k*DATA_W +: DATA_W]`.
- `pc` in 32: current CPU PC.
- `bp_en` in 1: breakpoint enable (level, not debounced).
- `bp_addr` in 32: breakpoint PC.
- `cpu_clk_en` out 1: one-`clk`-wide CPU clock-enable pulse.
- `sel` out `$clog2(CH_NUM)`: current channel index.
- `disp_data` out `DATA_W`: registered selected probe word, to `Display`.
- `run_mode` out 1: 1 = RUN, 0 = STEP.
- `bp_hit` out 1: sticky; run halted by breakpoint.
- `step_cnt` out 16: count of issued `cpu_clk_en` pulses.

## Operation
- Button path (identical per button): 2-FF synchroniser → debounce counter → stable level → rising-edge detector → one-cycle `press` pulse. The counter increments while the synchronised value ≠ stable level and clears when they are equal. When it reaches `DB_CYCLES`, stable takes the synchronised value and the counter clears. Release is debounced identically; falling edges produce no pulse.
- Channel select: `next` press → `sel` = `sel`+1, wrapping `CH_NUM-1`→0. `prev` press → `sel`-1, wrapping 0→`CH_NUM-1`. Both in the same cycle → `sel` unchanged.
- `disp_data` is registered every cycle from the channel addressed by the current `sel`, so probe changes are tracked live.
- FSM states:
  - STEP (reset state): a `step` press emits one `cpu_clk_en` pulse. A `run` press → RUN, clears `bp_hit`, and loads the divider with 0.
  - RUN: the divider counts 0..`RUN_DIV-1` and emits `cpu_clk_en` when it wraps to 0. A `run` press → STEP; no pulse is emitted in that cycle. `step` presses are ignored.
  - Breakpoint: in RUN with `bp_en`=1 and `pc`==`bp_addr` → STEP and `bp_hit`←1. This takes priority over a pulse due that cycle, so no pulse is emitted.
- `step_cnt` increments on every `cpu_clk_en` pulse and wraps 0xFFFF→0.
- Simultaneous `run` press and breakpoint in RUN → STEP with `bp_hit`=1.
- `bp_hit` is cleared only by reset or by entering RUN.

## Timing
- Reset (`rst`=0 at a rising edge): `cpu_clk_en`=0, `sel`=0, `disp_data`=0, `run_mode`=0, `bp_hit`=0, `step_cnt`=0. Synchronisers, stable levels, debounce counters and divider are all cleared. Reset applied mid-debounce or mid-run discards all progress; the first cycle after release is STEP with no pending press.
- Raw button rise held stable from edge t: `press` is high in cycle t+DB_CYCLES+3 (2 sync + DB_CYCLES count + 1 edge detect). A glitch shorter than `DB_CYCLES` cycles produces no press.
- Press → `sel` update: +1 cycle. Press → `cpu_clk_en` (STEP): +1 cycle.
- `sel` change → `disp_data`: +1 cycle. Probe change → `disp_data`: +1 cycle.
- In RUN, the first pulse comes `RUN_DIV` cycles after the mode change; subsequent pulses are exactly `RUN_DIV` cycles apart.
- Breakpoint: `pc` match in cycle c → `run_mode`=0 and `bp_hit`=1 visible at c+1.

## Test plan
Parameters for all scenarios: `CH_NUM`=4, `DB_CYCLES`=4, `RUN_DIV`=8.

- Debounce: `btn_step` 3-cycle glitch → no `cpu_clk_en`. `btn_step` held 20 cycles → exactly one pulse, at raw edge +8 cycles, and `step_cnt`=1.
- Select wrap: 4× `next` → `sel` 1,2,3,0. From 0, one `prev` → `sel`=3. With `probe_data` channel 3 = 0xDEADBEEF, `disp_data`=0xDEADBEEF one cycle after `sel`=3.
- Simultaneous: `next` and `prev` pressed in the same cycle → `sel` unchanged.
- Run mode: `run` press → `run_mode`=1 and pulses every 8 cycles. After 5 pulses, `run` press → `run_mode`=0, `step_cnt`=5, no further pulses. `step` presses during RUN are ignored.
- Breakpoint: `bp_en`=1, `bp_addr`=0x10, `pc` steps by 4 per pulse from 0 → halt when `pc`=0x10, `bp_hit`=1, `run_mode`=0. A later `run` press clears `bp_hit`.
- Reset: `rst`=0 in RUN with `sel`=2 and `step_cnt`=7 → next cycle all outputs 0. A debounce partially counted before reset yields no press after reset.
